lutram_fifo_ctrl: RTL and testbench
===================================

Name: lutram_fifo_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator on the `lutram` port set: it drives the write port and read address, and consumes the asynchronous read data.
- Converts a push/pop stream interface into `lutram` accesses, using the memory as FIFO storage.
- Instantiated beside an external `lutram` with matching `RAM_WIDTH`/`RAM_ADDR_BITS`. The memory itself lives outside this block.

Parameters:
- RAM_WIDTH, 16, data word width in bits.
- RAM_ADDR_BITS, 3, memory address width; FIFO depth DEPTH = 2**RAM_ADDR_BITS.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- push_i  input  1  write request from producer.
- wdata_i  input  RAM_WIDTH  data to enqueue.
- full_o  output  1  FIFO holds DEPTH words.
- pop_i  input  1  read/consume request from consumer.
- rdata_o  output  RAM_WIDTH  head-of-FIFO word (show-ahead); valid only when empty_o=0.
- empty_o  output  1  FIFO holds 0 words.
- count_o  output  RAM_ADDR_BITS+1  number of stored words, 0..DEPTH.
- overflow_o  output  1  sticky: push attempted while full.
- underflow_o  output  1  sticky: pop attempted while empty.
- mem_we_o  output  1  to lutram we_i.
- mem_waddr_o  output  RAM_ADDR_BITS  to lutram waddr_i.
- mem_wdata_o  output  RAM_WIDTH  to lutram wdata_i.
- mem_raddr_o  output  RAM_ADDR_BITS  to lutram raddr_i.
- mem_rdata_i  input  RAM_WIDTH  from lutram rdata_o (combinational read).

Behaviour:
- Clock/reset: one clock `clk_i`. Reset `rst_i` is asynchronous and active-high.
- State: wr_ptr and rd_ptr, each RAM_ADDR_BITS+1 bits (MSB is the wrap bit).
- Reset values: wr_ptr=0, rd_ptr=0, count_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0.
- Acceptance:
  - push_acc = push_i & ~full_o.
  - pop_acc = pop_i & ~empty_o.
  - Both flags are evaluated on the current-cycle registered state. There is no pass-through: a push while full is rejected even with a simultaneous pop. A pop while empty is rejected even with a simultaneous push.
- Write path (combinational):
  - mem_we_o = push_acc. With rst_i high, mem_we_o is forced to 0.
  - mem_waddr_o = wr_ptr[RAM_ADDR_BITS-1:0].
  - mem_wdata_o = wdata_i.
  - The memory captures the word on the same rising edge that advances wr_ptr.
- Read path (combinational):
  - mem_raddr_o = rd_ptr[RAM_ADDR_BITS-1:0].
  - rdata_o = mem_rdata_i.
  - Zero-cycle read latency: the head word is visible whenever empty_o=0. pop_acc advances rd_ptr at the edge, and the next word appears in the same cycle the pointer changes.
- Pointer update:
  - wr_ptr += push_acc; rd_ptr += pop_acc.
  - Both wrap naturally modulo 2**(RAM_ADDR_BITS+1).
  - The address wraps DEPTH-1 -> 0 while the MSB toggles.
- Flags, registered and derived from the next pointer values:
  - empty_o = (wr_ptr == rd_ptr).
  - full_o = (address bits equal) & (MSBs differ).
  - count_o = wr_ptr - rd_ptr, width RAM_ADDR_BITS+1, unsigned.
- Latency:
  - A push into an empty FIFO drops empty_o on the following clock edge.
  - rdata_o shows that word from then on, with no extra cycle.
- Simultaneous events:
  - push_acc & pop_acc in the same cycle: count unchanged; full_o/empty_o unchanged.
  - The write address and read address may coincide only when count=0 or count=DEPTH. In the first case pop is rejected; in the second, push is rejected. So no read-during-write hazard exists on an accepted pair.
- Error flags:
  - overflow_o is set on push_i & full_o.
  - underflow_o is set on pop_i & empty_o.
  - Both hold until reset. A rejected request changes no other state.
- Reset mid-operation:
  - Pointers and flags return to reset values immediately (asynchronous).
  - Memory contents are not cleared and are treated as invalid.
  - The first push after reset writes address 0.
- X-safety: pointers never take X after reset, regardless of push_i/pop_i being X while rst_i=1.

Test Plan:
- Reset then push 0x1111,0x2222,0x3333 on consecutive cycles -> mem_waddr_o sequence 0,1,2 with mem_we_o=1; count_o=3; empty_o=0; rdata_o=0x1111.
- Push 8 words 0xA000..0xA007 (DEPTH=8) -> full_o=1, count_o=8 after the 8th edge. A 9th push -> mem_we_o stays 0, overflow_o=1, count_o stays 8.
- From full, pop 8 times -> rdata_o presents 0xA000..0xA007 in order, one per cycle, each before its pop edge. Then empty_o=1 and count_o=0. A 9th pop -> underflow_o=1, rd_ptr unchanged.
- Wrap-around: push 6, pop 6, then push 4 (0xB000..0xB003) -> writes go to addresses 6,7,0,1. Pops return 0xB000..0xB003 from raddr 6,7,0,1. Never full.
- Simultaneous: count=3, push 0xC0DE and pop together for 5 cycles -> count_o stays 3, ordering preserved. With count=0, push+pop -> pop rejected, count_o=1, underflow_o=1. With count=8, push+pop -> push rejected, count_o=7, overflow_o=1.
- Async reset mid-stream: assert rst_i between clock edges while count=5 -> empty_o=1, count_o=0, both sticky flags=0 immediately. The next push writes address 0.

Source files
------------

// File: rtl/lutram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lutram_fifo_ctrl
// Brief    : Show-ahead FIFO controller driving an external async-read LUTRAM.
// Revision : 1.0 - initial release
// ============================================================================
module lutram_fifo_ctrl #(
  parameter int RAM_WIDTH     = 16,
  parameter int RAM_ADDR_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [RAM_WIDTH-1:0]     wdata_i,
  output logic                     full_o,
  input  logic                     pop_i,
  output logic [RAM_WIDTH-1:0]     rdata_o,
  output logic                     empty_o,
  output logic [RAM_ADDR_BITS:0]   count_o,
  output logic                     overflow_o,
  output logic                     underflow_o,
  output logic                     mem_we_o,
  output logic [RAM_ADDR_BITS-1:0] mem_waddr_o,
  output logic [RAM_WIDTH-1:0]     mem_wdata_o,
  output logic [RAM_ADDR_BITS-1:0] mem_raddr_o,
  input  logic [RAM_WIDTH-1:0]     mem_rdata_i
);

  localparam int c_PTR_W = RAM_ADDR_BITS + 1;

  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W-1:0] r_count;
  logic               r_full;
  logic               r_empty;
  logic               r_overflow;
  logic               r_underflow;

  logic               w_push_acc;
  logic               w_pop_acc;
  logic [c_PTR_W-1:0] w_wr_nxt;
  logic [c_PTR_W-1:0] w_rd_nxt;

  // Acceptance uses only registered flags: no pass-through at full or empty.
  assign w_push_acc = push_i & ~r_full;
  assign w_pop_acc  = pop_i & ~r_empty;

  assign w_wr_nxt = r_wr_ptr + c_PTR_W'(w_push_acc);
  assign w_rd_nxt = r_rd_ptr + c_PTR_W'(w_pop_acc);

  assign mem_we_o    = w_push_acc & ~rst_i;
  assign mem_waddr_o = r_wr_ptr[RAM_ADDR_BITS-1:0];
  assign mem_wdata_o = wdata_i;
  assign mem_raddr_o = r_rd_ptr[RAM_ADDR_BITS-1:0];
  assign rdata_o     = mem_rdata_i;

  assign full_o      = r_full;
  assign empty_o     = r_empty;
  assign count_o     = r_count;
  assign overflow_o  = r_overflow;
  assign underflow_o = r_underflow;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_nxt;
      r_rd_ptr <= w_rd_nxt;
      r_count  <= w_wr_nxt - w_rd_nxt;
      r_empty  <= (w_wr_nxt == w_rd_nxt);
      // Same address with opposite wrap bits means the writer lapped the reader.
      r_full   <= (w_wr_nxt[RAM_ADDR_BITS-1:0] == w_rd_nxt[RAM_ADDR_BITS-1:0]) &&
                  (w_wr_nxt[RAM_ADDR_BITS] != w_rd_nxt[RAM_ADDR_BITS]);
      if (push_i && r_full) begin
        r_overflow <= 1'b1;
      end
      if (pop_i && r_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lutram_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lutram_fifo_ctrl
// Brief    : Directed self-checking bench for lutram_fifo_ctrl with a LUTRAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lutram_fifo_ctrl;

  localparam int RAM_WIDTH     = 16;
  localparam int RAM_ADDR_BITS = 3;
  localparam int DEPTH         = 8;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic                     push = 1'b0;
  logic [RAM_WIDTH-1:0]     wdata = '0;
  logic                     pop = 1'b0;
  logic                     full, empty, overflow, underflow, mem_we;
  logic [RAM_WIDTH-1:0]     rdata, mem_wdata, mem_rdata;
  logic [RAM_ADDR_BITS:0]   count;
  logic [RAM_ADDR_BITS-1:0] mem_waddr, mem_raddr;
  logic [RAM_WIDTH-1:0]     mem [0:DEPTH-1];

  int n_cmp = 0;
  int n_err = 0;

  lutram_fifo_ctrl #(.RAM_WIDTH(RAM_WIDTH), .RAM_ADDR_BITS(RAM_ADDR_BITS)) dut (
    .clk_i(clk), .rst_i(rst), .push_i(push), .wdata_i(wdata), .full_o(full),
    .pop_i(pop), .rdata_o(rdata), .empty_o(empty), .count_o(count),
    .overflow_o(overflow), .underflow_o(underflow), .mem_we_o(mem_we),
    .mem_waddr_o(mem_waddr), .mem_wdata_o(mem_wdata), .mem_raddr_o(mem_raddr),
    .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // External LUTRAM model: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign mem_rdata = mem[mem_raddr];

  task automatic drive(input logic p, input logic [RAM_WIDTH-1:0] d, input logic q);
    @(negedge clk);
    push = p; wdata = d; pop = q;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; push = 1'bx; pop = 1'bx;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_we got=%b exp=0", mem_we); end
    tick();
    n_cmp++; if (count !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if ({empty, full, overflow, underflow} !== 4'b1000)
      begin n_err++; $display("FAIL reset_flags got=%b exp=1000", {empty, full, overflow, underflow}); end
    @(negedge clk);
    push = 1'b0; pop = 1'b0; rst = 1'b0;
    tick();
    n_cmp++; if (count !== 4'd0 || mem_waddr !== 3'd0 || mem_raddr !== 3'd0)
      begin n_err++; $display("FAIL reset_ptrs got=%0d/%0d/%0d exp=0/0/0", count, mem_waddr, mem_raddr); end
  endtask

  task automatic test_push3();
    logic [RAM_WIDTH-1:0] d [3] = '{16'h1111, 16'h2222, 16'h3333};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, d[i], 1'b0);
      n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 3'(i))
        begin n_err++; $display("FAIL push3_write got=%b/%0d exp=1/%0d", mem_we, mem_waddr, i); end
      tick();
    end
    drive(1'b0, '0, 1'b0);
    n_cmp++; if (count !== 4'd3 || empty !== 1'b0)
      begin n_err++; $display("FAIL push3_state got=%0d/%b exp=3/0", count, empty); end
    n_cmp++; if (rdata !== 16'h1111) begin n_err++; $display("FAIL push3_head got=%h exp=1111", rdata); end
  endtask

  task automatic test_full_and_drain();
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 16'hA000 + 16'(i), 1'b0);
      tick();
      n_cmp++; if (full !== (i == DEPTH - 1))
        begin n_err++; $display("FAIL fill_full i=%0d got=%b exp=%b", i, full, i == DEPTH - 1); end
    end
    n_cmp++; if (count !== 4'd8) begin n_err++; $display("FAIL fill_count got=%0d exp=8", count); end
    drive(1'b1, 16'hDEAD, 1'b0);
    n_cmp++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL ovf_we got=%b exp=0", mem_we); end
    tick();
    n_cmp++; if (overflow !== 1'b1 || count !== 4'd8 || underflow !== 1'b0)
      begin n_err++; $display("FAIL ovf_state got=%b/%0d/%b exp=1/8/0", overflow, count, underflow); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      n_cmp++; if (rdata !== 16'hA000 + 16'(i) || mem_raddr !== 3'(i))
        begin n_err++; $display("FAIL drain_data i=%0d got=%h@%0d exp=%h@%0d", i, rdata, mem_raddr, 16'hA000 + 16'(i), i); end
      tick();
    end
    n_cmp++; if (empty !== 1'b1 || count !== 4'd0)
      begin n_err++; $display("FAIL drain_empty got=%b/%0d exp=1/0", empty, count); end
    drive(1'b0, '0, 1'b1);
    tick();
    n_cmp++; if (underflow !== 1'b1 || mem_raddr !== 3'd0 || count !== 4'd0)
      begin n_err++; $display("FAIL unf_state got=%b/%0d/%0d exp=1/0/0", underflow, mem_raddr, count); end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 6; i++) begin drive(1'b1, 16'h5000 + 16'(i), 1'b0); tick(); end
    for (int i = 0; i < 6; i++) begin drive(1'b0, '0, 1'b1); tick(); end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'hB000 + 16'(i), 1'b0);
      n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 3'((6 + i) % DEPTH))
        begin n_err++; $display("FAIL wrap_waddr i=%0d got=%0d exp=%0d", i, mem_waddr, (6 + i) % DEPTH); end
      tick();
      n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL wrap_full i=%0d got=%b exp=0", i, full); end
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, '0, 1'b1);
      n_cmp++; if (rdata !== 16'hB000 + 16'(i) || mem_raddr !== 3'((6 + i) % DEPTH))
        begin n_err++; $display("FAIL wrap_read i=%0d got=%h@%0d exp=%h@%0d", i, rdata, mem_raddr, 16'hB000 + 16'(i), (6 + i) % DEPTH); end
      tick();
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty got=%b exp=1", empty); end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [RAM_WIDTH-1:0] q[$];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'hD000 + 16'(i), 1'b0); q.push_back(16'hD000 + 16'(i)); tick();
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'hC0D0 + 16'(i), 1'b1);
      n_cmp++; if (rdata !== q[0]) begin n_err++; $display("FAIL b2b_head i=%0d got=%h exp=%h", i, rdata, q[0]); end
      void'(q.pop_front()); q.push_back(16'hC0D0 + 16'(i));
      tick();
      n_cmp++; if (count !== 4'd3) begin n_err++; $display("FAIL b2b_count i=%0d got=%0d exp=3", i, count); end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1);
      n_cmp++; if (rdata !== q[0]) begin n_err++; $display("FAIL b2b_tail i=%0d got=%h exp=%h", i, rdata, q[0]); end
      void'(q.pop_front());
      tick();
    end
    // Empty: push accepted, pop rejected.
    drive(1'b1, 16'hE0E0, 1'b1);
    tick();
    n_cmp++; if (count !== 4'd1 || underflow !== 1'b1 || rdata !== 16'hE0E0)
      begin n_err++; $display("FAIL empty_pp got=%0d/%b/%h exp=1/1/e0e0", count, underflow, rdata); end
    // Full: pop accepted, push rejected.
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin drive(1'b1, 16'hF000 + 16'(i), 1'b0); tick(); end
    drive(1'b1, 16'hFFFF, 1'b1);
    tick();
    n_cmp++; if (count !== 4'd7 || overflow !== 1'b1 || full !== 1'b0 || rdata !== 16'hF001)
      begin n_err++; $display("FAIL full_pp got=%0d/%b/%b/%h exp=7/1/0/f001", count, overflow, full, rdata); end
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b0, '0, 1'b1); tick();
    for (int i = 0; i < DEPTH + 1; i++) begin drive(1'b1, 16'h7000 + 16'(i), 1'b0); tick(); end
    for (int i = 0; i < 3; i++) begin drive(1'b0, '0, 1'b1); tick(); end
    drive(1'b0, '0, 1'b0);
    n_cmp++; if (count !== 4'd5 || overflow !== 1'b1 || underflow !== 1'b1)
      begin n_err++; $display("FAIL arst_pre got=%0d/%b/%b exp=5/1/1", count, overflow, underflow); end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (empty !== 1'b1 || count !== 4'd0 || overflow !== 1'b0 || underflow !== 1'b0)
      begin n_err++; $display("FAIL arst_now got=%b/%0d/%b/%b exp=1/0/0/0", empty, count, overflow, underflow); end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 16'h0ABC, 1'b0);
    n_cmp++; if (mem_we !== 1'b1 || mem_waddr !== 3'd0)
      begin n_err++; $display("FAIL arst_first got=%b/%0d exp=1/0", mem_we, mem_waddr); end
    tick();
    drive(1'b0, '0, 1'b0);
    n_cmp++; if (count !== 4'd1 || rdata !== 16'h0ABC)
      begin n_err++; $display("FAIL arst_data got=%0d/%h exp=1/0abc", count, rdata); end
  endtask

  initial begin
    test_reset();
    test_push3();
    test_full_and_drain();
    test_wrap();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
